// File: rtl/ysyx_24080006_pkg.sv
// Shared geometry, line-entry type and FSM encoding for the instruction cache controller.
package ysyx_24080006_pkg;

  localparam int ADDR_W   = 32;
  localparam int IC_N     = 4;
  localparam int IC_2     = 2 ** IC_N;
  localparam int IC_WORDS = 4;
  localparam int OFF_W    = $clog2(IC_WORDS * 4);
  localparam int WOFF_W   = $clog2(IC_WORDS);
  localparam int TAG_W    = ADDR_W - IC_N - OFF_W;

  localparam logic [7:0] AXI_LEN        = 8'(IC_WORDS - 1);
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic                       valid;
    logic [TAG_W-1:0]           tag;
    logic [IC_WORDS-1:0][31:0]  data;
  } icache_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_AR,
    ST_R,
    ST_FILL,
    ST_RSP,
    ST_FENCE
  } ic_state_e;

  function automatic logic [IC_N-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFF_W+IC_N-1:OFF_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFF_W+IC_N];
  endfunction

  function automatic logic [WOFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:2];
  endfunction

endpackage

// File: rtl/ysyx_24080006_icache_ctrl_if.sv
// IFU fetch, FENCE.I, icache regfile and AXI read-channel signals of the icache controller.
interface ysyx_24080006_icache_ctrl_if;
  import ysyx_24080006_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [31:0]       ifu_rsp_inst;
  logic              ifu_rsp_err;

  logic              fencei_req;
  logic              fencei_done;

  logic [IC_N-1:0]   ic_index;
  icache_t           ic_rdata;
  logic              ic_we;
  logic [IC_N-1:0]   ic_waddr;
  icache_t           ic_wdata;
  logic              fencei;

  logic [ADDR_W-1:0] axi_araddr;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [31:0]       axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready, fencei_req, ic_rdata,
           axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err, fencei_done,
           ic_index, ic_we, ic_waddr, ic_wdata, fencei,
           axi_araddr, axi_arvalid, axi_arlen, axi_arsize, axi_arburst, axi_rready
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready, fencei_req, ic_rdata,
           axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err, fencei_done,
           ic_index, ic_we, ic_waddr, ic_wdata, fencei,
           axi_araddr, axi_arvalid, axi_arlen, axi_arsize, axi_arburst, axi_rready
  );

endinterface

// File: rtl/ysyx_24080006_icache_ctrl.sv
// Direct-mapped icache controller: lookup, AXI INCR line refill, FENCE.I sequencing.
// Define YSYX_24080006_ICACHE_PERF_EN to add hit/miss performance counters.
module ysyx_24080006_icache_ctrl
  import ysyx_24080006_pkg::*;
(
  input  logic clock,
  input  logic reset,
  ysyx_24080006_icache_ctrl_if.master bus
`ifdef YSYX_24080006_ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  ic_state_e                 state_q;
  logic [TAG_W-1:0]          tag_q;
  logic [WOFF_W-1:0]         woff_q;
  logic [IC_N-1:0]           ic_index_q;
  logic [IC_WORDS-1:0][31:0] line_q;
  logic [IC_WORDS-1:0][31:0] line_d;
  logic [WOFF_W-1:0]         cnt_q;
  logic                      err_flag_q;
  logic                      err_d;
  logic                      rsp_valid_q;
  logic [31:0]               rsp_inst_q;
  logic                      rsp_err_q;
  logic                      arvalid_q;
  logic [ADDR_W-1:0]         araddr_q;
  logic                      rready_q;
  logic                      ic_we_q;
  logic [IC_N-1:0]           ic_waddr_q;
  icache_t                   ic_wdata_q;
  logic                      fencei_q;
  icache_t                   rd;
  logic                      hit;
  logic                      unused_addr_lsb;

  assign unused_addr_lsb = ^bus.ifu_addr[1:0];
  assign rd  = bus.ic_rdata;
  assign hit = rd.valid && (rd.tag == tag_q);

  // Line buffer merged with the beat arriving this cycle, so FILL can write the last beat too.
  always_comb begin
    line_d = line_q;
    err_d  = err_flag_q;
    if (bus.axi_rvalid && rready_q) begin
      line_d[cnt_q] = bus.axi_rdata;
      err_d         = err_flag_q | (|bus.axi_rresp);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      woff_q      <= '0;
      ic_index_q  <= '0;
      line_q      <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      ic_we_q     <= 1'b0;
      ic_waddr_q  <= '0;
      ic_wdata_q  <= '0;
      fencei_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.fencei_req) begin
            fencei_q <= 1'b1;
            state_q  <= ST_FENCE;
          end else if (bus.ifu_req_valid) begin
            tag_q      <= addr_tag(bus.ifu_addr);
            woff_q     <= addr_word(bus.ifu_addr);
            ic_index_q <= addr_index(bus.ifu_addr);
            state_q    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= rd.data[woff_q];
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RSP;
          end else begin
            arvalid_q <= 1'b1;
            araddr_q  <= {tag_q, ic_index_q, {OFF_W{1'b0}}};
            state_q   <= ST_AR;
          end
        end
        ST_AR: begin
          if (bus.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (bus.axi_rvalid) begin
            line_q     <= line_d;
            err_flag_q <= err_d;
            cnt_q      <= cnt_q + 1'b1;
            // rlast ends the burst regardless of how many beats were counted.
            if (bus.axi_rlast) begin
              rready_q   <= 1'b0;
              ic_we_q    <= !err_d;
              ic_waddr_q <= ic_index_q;
              ic_wdata_q <= '{valid: 1'b1, tag: tag_q, data: line_d};
              state_q    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          ic_we_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_inst_q  <= err_flag_q ? 32'd0 : line_q[woff_q];
          rsp_err_q   <= err_flag_q;
          state_q     <= ST_RSP;
        end
        ST_RSP: begin
          if (bus.ifu_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_flag_q  <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end
        end
        ST_FENCE: begin
          fencei_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A pending FENCE.I blocks new fetches so the invalidate is never overtaken.
  assign bus.ifu_req_ready = (state_q == ST_IDLE) && !bus.fencei_req && !reset;
  assign bus.ifu_rsp_valid = rsp_valid_q;
  assign bus.ifu_rsp_inst  = rsp_inst_q;
  assign bus.ifu_rsp_err   = rsp_err_q;
  assign bus.fencei        = fencei_q;
  assign bus.fencei_done   = fencei_q;
  assign bus.ic_index      = ic_index_q;
  assign bus.ic_we         = ic_we_q;
  assign bus.ic_waddr      = ic_waddr_q;
  assign bus.ic_wdata      = ic_wdata_q;
  assign bus.axi_araddr    = araddr_q;
  assign bus.axi_arvalid   = arvalid_q;
  assign bus.axi_arlen     = arvalid_q ? AXI_LEN : 8'd0;
  assign bus.axi_arsize    = arvalid_q ? AXI_SIZE_4B : 3'd0;
  assign bus.axi_arburst   = arvalid_q ? AXI_BURST_INCR : 2'd0;
  assign bus.axi_rready    = rready_q;

`ifdef YSYX_24080006_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_24080006_icache_ctrl.sv
// Directed bench for the icache controller with regfile model, AXI slave model and response scoreboard.
module tb_ysyx_24080006_icache_ctrl;
  import ysyx_24080006_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ysyx_24080006_icache_ctrl_if bus ();

  ysyx_24080006_icache_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Regfile model: write on clock, invalidate on fencei or reset, same-cycle write bypass on read.
  icache_t mem [IC_2];
  always @(posedge clock) begin
    if (reset || bus.fencei) begin
      for (int i = 0; i < IC_2; i++) mem[i].valid <= 1'b0;
    end else if (bus.ic_we) begin
      mem[bus.ic_waddr] <= bus.ic_wdata;
    end
  end
  assign bus.ic_rdata = (bus.ic_we && bus.ic_waddr == bus.ic_index) ? bus.ic_wdata : mem[bus.ic_index];

  // AXI read slave model: grants AR for one cycle, then returns IC_WORDS beats.
  int          beat_val [16];
  int          err_beat = -1;
  int          ar_cnt = 0;
  int          s_acc = 0;
  logic [31:0] last_araddr;
  logic [7:0]  last_arlen;
  logic [2:0]  last_arsize;
  logic [1:0]  last_arburst;

  task automatic drive_beat(input int b);
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = beat_val[b];
    bus.axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
    bus.axi_rlast  = (b == IC_WORDS - 1);
  endtask

  initial begin : axi_slave
    int st;
    int beat;
    bit pend;
    st = 0; beat = 0; pend = 0;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00; bus.axi_rlast = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0;
        bus.axi_rresp = 2'b00; st = 0; pend = 0;
      end else begin
        case (st)
          0: if (bus.axi_arvalid) begin
            bus.axi_arready = 1'b1;
            ar_cnt++;
            s_acc = 0;
            last_araddr = bus.axi_araddr; last_arlen = bus.axi_arlen;
            last_arsize = bus.axi_arsize; last_arburst = bus.axi_arburst;
            st = 1;
          end
          1: begin
            bus.axi_arready = 1'b0;
            beat = 0;
            drive_beat(0);
            pend = bus.axi_rready;
            st = 2;
          end
          default: begin
            if (pend) begin
              s_acc++;
              if (bus.axi_rlast) begin
                bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0; bus.axi_rresp = 2'b00;
                st = 0;
              end else begin
                beat++;
                drive_beat(beat);
              end
            end
            pend = bus.axi_rvalid && bus.axi_rready;
          end
        endcase
      end
    end
  end

  // Response / regfile-write monitor, sampling mid-cycle.
  rsp_t        sb_q [$];
  int          rsp_cnt = 0;
  int          we_cnt = 0;
  int          first_valid_cyc = 0;
  logic [IC_N-1:0] last_waddr;
  icache_t     last_wdata;

  initial begin : monitor
    bit          prev_v;
    bit          prev_rdy;
    logic [31:0] prev_inst;
    logic        prev_err;
    rsp_t        e;
    prev_v = 0; prev_rdy = 0; prev_inst = '0; prev_err = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        prev_v = 0;
      end else begin
        if (bus.ifu_rsp_valid && !prev_v) first_valid_cyc = cyc;
        if (prev_v && !prev_rdy && bus.ifu_rsp_valid)
          chk("rsp_stable", {bus.ifu_rsp_inst, bus.ifu_rsp_err}, {prev_inst, prev_err});
        if (bus.ifu_rsp_valid && bus.ifu_rsp_ready) begin
          if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_inst", bus.ifu_rsp_inst, e.inst);
            chk("rsp_err", bus.ifu_rsp_err, e.err);
          end
          rsp_cnt++;
        end
        if (bus.ic_we) begin
          we_cnt++;
          last_waddr = bus.ic_waddr;
          last_wdata = bus.ic_wdata;
        end
        prev_v = bus.ifu_rsp_valid; prev_rdy = bus.ifu_rsp_ready;
        prev_inst = bus.ifu_rsp_inst; prev_err = bus.ifu_rsp_err;
      end
    end
  end

  task automatic set_line(input int base, input int step);
    for (int i = 0; i < 16; i++) beat_val[i] = base + step * i;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                       input bit miss, input int stall);
    int ar0, we0, r0, hs_cyc, n;
    ar0 = ar_cnt; we0 = we_cnt; r0 = rsp_cnt;
    @(negedge clock);
    sb_q.push_back('{inst: ei, err: ee});
    bus.ifu_rsp_ready = (stall == 0);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = a;
    #2;
    n = 0;
    while (!bus.ifu_req_ready && n < 50) begin @(negedge clock); #2; n++; end
    chk("req_ready", bus.ifu_req_ready, 1'b1);
    hs_cyc = cyc;
    @(negedge clock);
    bus.ifu_req_valid = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(negedge clock);
      bus.ifu_rsp_ready = 1'b1;
    end
    #2;
    n = 0;
    while (rsp_cnt == r0 && n < 200) begin @(negedge clock); #2; n++; end
    chk("rsp_timeout", rsp_cnt != r0, 1'b1);
    chk("ar_count", ar_cnt - ar0, miss ? 1 : 0);
    chk("we_count", we_cnt - we0, (miss && !ee) ? 1 : 0);
    if (!miss && stall == 0) chk("hit_latency", first_valid_cyc - hs_cyc, 2);
    $display("fetch addr=%h inst=%h err=%0d miss=%0d", a, ei, ee, miss);
  endtask

  icache_t exp_line;
  int      n;

  initial begin
    reset = 1'b1;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0; bus.ifu_rsp_ready = 1'b1; bus.fencei_req = 1'b0;
    set_line(32'h11, 32'h11);
    repeat (2) @(negedge clock);
    #2;
    chk("reset_outputs", {bus.ifu_rsp_valid, bus.ifu_rsp_inst, bus.ifu_rsp_err, bus.axi_arvalid,
        bus.axi_araddr, bus.axi_rready, bus.ic_we, bus.fencei, bus.fencei_done, bus.ifu_req_ready,
        bus.axi_arlen}, '0);
    reset = 1'b0;
    @(negedge clock); #2;
    chk("idle_ready", bus.ifu_req_ready, 1'b1);

    // Cold miss with critical word at offset 1.
    fetch(32'h8000_0004, 32'h22, 1'b0, 1'b1, 0);
    chk("araddr", last_araddr, 32'h8000_0000);
    chk("arlen", last_arlen, 8'd3);
    chk("arsize_burst", {last_arsize, last_arburst}, 5'b010_01);
    chk("waddr", last_waddr, 4'd0);
    exp_line.valid = 1'b1;
    exp_line.tag = TAG_W'(32'h8000_0000 >> (OFF_W + IC_N));
    for (int i = 0; i < IC_WORDS; i++) exp_line.data[i] = 32'h11 * (i + 1);
    chk("wdata", last_wdata, exp_line);

    // Hits, then a hit with response backpressure.
    fetch(32'h8000_0008, 32'h33, 1'b0, 1'b0, 0);
    fetch(32'h8000_000C, 32'h44, 1'b0, 1'b0, 3);

    // Conflict on index 0 with a new tag.
    set_line(32'hA0, 1);
    fetch(32'h8000_0100, 32'hA0, 1'b0, 1'b1, 0);
    chk("conflict_waddr", last_waddr, 4'd0);
    chk("conflict_tag", last_wdata.tag, TAG_W'(32'h8000_0100 >> (OFF_W + IC_N)));
    set_line(32'h11, 32'h11);
    fetch(32'h8000_0000, 32'h11, 1'b0, 1'b1, 0);

    // Bus error on beat 2: no write, refetch misses again.
    set_line(32'h50, 1);
    err_beat = 2;
    fetch(32'h8000_0014, 32'h0, 1'b1, 1'b1, 0);
    err_beat = -1;
    fetch(32'h8000_0014, 32'h51, 1'b0, 1'b1, 0);

    // FENCE.I together with a fetch request.
    @(negedge clock);
    bus.fencei_req = 1'b1; bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0004;
    #2;
    chk("fence_blocks_req", bus.ifu_req_ready, 1'b0);
    @(negedge clock); #2;
    chk("fence_pulse", {bus.fencei, bus.fencei_done, bus.ifu_req_ready}, 3'b110);
    bus.fencei_req = 1'b0; bus.ifu_req_valid = 1'b0;
    @(negedge clock); #2;
    chk("fence_one_cycle", {bus.fencei, bus.fencei_done}, 2'b00);
    set_line(32'h11, 32'h11);
    fetch(32'h8000_0004, 32'h22, 1'b0, 1'b1, 0);

    // Reset in the middle of a refill burst.
    set_line(32'h60, 1);
    @(negedge clock);
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0024;
    #2;
    chk("rst_req_ready", bus.ifu_req_ready, 1'b1);
    @(negedge clock);
    bus.ifu_req_valid = 1'b0;
    #2;
    n = 0;
    while (s_acc < 1 && n < 100) begin @(negedge clock); #2; n++; end
    chk("rst_beat_seen", s_acc >= 1, 1'b1);
    reset = 1'b1;
    @(negedge clock); #2;
    chk("rst_mid_burst", {bus.axi_rready, bus.ifu_rsp_valid, bus.axi_arvalid, bus.ic_we}, 4'b0000);
    reset = 1'b0;
    @(negedge clock); #2;
    chk("rst_back_idle", bus.ifu_req_ready, 1'b1);
    $display("reset during refill of 8000_0024 done");
    set_line(32'h11, 32'h11);
    fetch(32'h8000_0004, 32'h22, 1'b0, 1'b1, 0);
    set_line(32'h60, 1);
    fetch(32'h8000_0024, 32'h61, 1'b0, 1'b1, 0);

    repeat (2) @(negedge clock);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_icache_ctrl.md
Name: ysyx_24080006_icache_ctrl

Overview:
Controller for the direct-mapped instruction cache: accepts IFU fetch requests, looks up the icache regfile, refills missed lines with an AXI4 INCR read burst and returns the fetched instruction. Also sequences FENCE.I invalidation. Sits in the IF stage between the IFU fetch logic, `ysyx_24080006_icache_regfile` and the AXI read master port.

Parameters:
IC_N, 4, index bits; IC_2 = 2**IC_N lines
IC_WORDS, 4, 32-bit words per line (power of two, 2..16)
ADDR_W, 32, byte address width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  controller can accept a request
ifu_addr  in  ADDR_W  fetch byte address, word aligned
ifu_rsp_valid  out  1  response valid, held until accepted
ifu_rsp_ready  in  1  IFU accepts response
ifu_rsp_inst  out  32  instruction word
ifu_rsp_err  out  1  bus error on refill
fencei_req  in  1  FENCE.I request, level
fencei_done  out  1  one-cycle pulse, invalidation complete
ic_index  out  IC_N  regfile read index
ic_rdata  in  icache_t  regfile read entry, with same-cycle write bypass
ic_we  out  1  regfile write enable
ic_waddr  out  IC_N  regfile write index
ic_wdata  out  icache_t  regfile write entry
fencei  out  1  regfile invalidate-all strobe
axi_araddr  out  ADDR_W  line-aligned burst address
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address ready
axi_arlen  out  8  IC_WORDS-1
axi_arsize  out  3  3'b010
axi_arburst  out  2  2'b01 (INCR)
axi_rvalid  in  1  read data valid
axi_rready  out  1  read data ready
axi_rdata  in  32  read data beat
axi_rresp  in  2  beat response
axi_rlast  in  1  last beat

Behaviour:
- Address split: offset = addr[OFF_W-1:0] with OFF_W = log2(IC_WORDS*4); index = addr[OFF_W+IC_N-1:OFF_W]; tag = remaining upper bits.
- States: IDLE, LOOKUP, AR, R, FILL, RSP, FENCE. All outputs are 0 in reset; state resets to IDLE; beat counter and error flag reset to 0.
- IDLE: `ifu_req_ready`=1 only when `fencei_req`=0. If `fencei_req`=1, go to FENCE; fencei takes priority over a simultaneous request. On a request handshake, latch the address and go to LOOKUP.
- LOOKUP: `ic_index` = latched index. Hit when `valid` is set and the tag matches; go to RSP with the selected word. Miss: go to AR.
- Hit latency: request handshake at cycle N gives `ifu_rsp_valid` at cycle N+2.
- AR: `arvalid`=1 and `araddr` = {tag, index, OFF_W'0}. On `arready`, go to R. `araddr` and the other AR fields stay stable while stalled.
- R: `rready`=1. Each beat is stored into the line buffer at the beat counter, and the counter increments. Any `rresp`≠0 sets the sticky error flag. On `rlast`, go to FILL. `rlast` is honoured even if the beat count differs from IC_WORDS.
- FILL (one cycle):
  - Error flag clear: `ic_we`=1 and `ic_wdata` = {valid=1, tag, buffer}.
  - Error flag set: no write; error response carries inst=0 and err=1.
  - Always go to RSP; the instruction is taken from the buffer at the word offset (critical word).
- RSP: `ifu_rsp_valid`=1 with inst and err held stable until `ifu_rsp_ready`; then go to IDLE and clear the error flag and beat counter.
- FENCE: `fencei`=1 and `fencei_done`=1 for one cycle, then IDLE. The IDLE→FENCE check requires `fencei_req` to be sampled again before re-entering. The requester deasserts `fencei_req` on `fencei_done`.
- A `fencei_req` arriving during a miss is serviced only after RSP completes, so the refill is written before the invalidate.
- Reset in any state returns to IDLE immediately. The AXI slave is reset by the same signal, so no outstanding burst is drained.

Optional Feature:
Macro: YSYX_24080006_ICACHE_PERF_EN.
- Enabled: adds outputs `perf_hit_cnt[31:0]` and `perf_miss_cnt[31:0]`.
  - Hit counter increments on each LOOKUP hit.
  - Miss counter increments on each LOOKUP miss.
  - Both wrap at 2^32, are zeroed by reset and are not cleared by FENCE.I.
- Disabled: neither the ports nor the logic exist.

Decomposition:
- Package `ysyx_24080006_pkg` holds: IC_N, IC_2, IC_WORDS, OFF_W, TAG_W, the `icache_t` struct {valid, tag[TAG_W], data[IC_WORDS][32]}, the state enum `ic_state_e`, and the AXI burst/size constants.
- No sub-module; the line buffer is internal.

Test Plan:
- Cold miss at 0x8000_0004: AXI returns 4 beats 0x11,0x22,0x33,0x44 with rresp=0 → one AR with araddr=0x8000_0000 and arlen=3; one `ic_we` to index 0 with valid=1; response inst=0x22, err=0.
- Repeat fetch of 0x8000_0008 → no AR; `ifu_rsp_valid` two cycles after the handshake; inst=0x33.
- Conflict: fetch 0x8000_0100 with IC_N=4, which maps to the same index with a new tag → miss, refill, entry overwritten; fetching 0x8000_0000 again then misses.
- Bus error: beat 2 has rresp=2'b10 → no `ic_we`; response err=1, inst=0; a refetch of the same address misses again.
- FENCE.I asserted together with `ifu_req_valid` in IDLE → `fencei`=1 and `fencei_done`=1 for one cycle with `ifu_req_ready`=0; the next fetch of 0x8000_0004 misses.
- Reset asserted in R after beat 1 → next cycle state IDLE, `axi_rready`=0, `ifu_rsp_valid`=0; later fetches miss.
